// File: rtl/usb_pkg.sv
// Shared USB constants: packet request codes, PID/SYNC bytes, CRC16 parameters and line states.
package usb_pkg;

    localparam logic [1:0] PKT_IDLE  = 2'b00;
    localparam logic [1:0] PKT_DATA0 = 2'b01;
    localparam logic [1:0] PKT_ACK   = 2'b10;
    localparam logic [1:0] PKT_NAK   = 2'b11;

    localparam logic [7:0] SYNC_BYTE = 8'h80;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;

    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef struct packed {
        logic dp;
        logic dm;
    } line_t;

    localparam line_t LINE_J   = '{dp: 1'b1, dm: 1'b0};
    localparam line_t LINE_K   = '{dp: 1'b0, dm: 1'b1};
    localparam line_t LINE_SE0 = '{dp: 1'b0, dm: 1'b0};

    function automatic logic [7:0] pid_byte(input logic [1:0] pkt);
        case (pkt)
            PKT_DATA0: return PID_DATA0;
            PKT_ACK:   return PID_ACK;
            default:   return PID_NAK;
        endcase
    endfunction

    function automatic logic [15:0] rev16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

    // NRZI: a 0 toggles the line level, a 1 holds it.
    function automatic logic nrzi(input logic lvl, input logic b);
        return b ? lvl : ~lvl;
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Serial CRC16 (x^16+x^15+x^2+1), one data bit per enabled cycle, MSB-feedback form.
// Latency: register updates on the enabled edge.
// Backpressure: none; caller gates with en.
module usb_crc16
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);
    logic fb;

    assign fb = din ^ crc[15];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            crc <= 16'h0000;
        end else if (clr) begin
            crc <= CRC16_INIT;
        end else if (en) begin
            crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/usb_tx.sv
// USB low-level packet transmitter: SYNC, PID, optional DATA+CRC16, EOP with bit stuffing and NRZI.
// Latency: first SYNC bit on the lines the cycle after acceptance; each bit lasts BIT_CLKS cycles.
// Backpressure: requests are only taken in IDLE; data bytes are popped at byte boundaries.
module usb_tx
    import usb_pkg::*;
#(
    parameter int BIT_CLKS = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [1:0] tx_packet,
    input  logic [7:0] tx_packet_data,
    input  logic [6:0] buffer_occupancy,
    output logic       get_tx_packet_data,
    output logic       tx_done,
    output logic       tx_busy,
    output logic       dplus_out,
    output logic       dminus_out
);
    localparam int CNT_W = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SYNC    = 3'd1;
    localparam logic [2:0] ST_PID     = 3'd2;
    localparam logic [2:0] ST_DATA    = 3'd3;
    localparam logic [2:0] ST_CRC     = 3'd4;
    localparam logic [2:0] ST_EOP_SE0 = 3'd5;
    localparam logic [2:0] ST_EOP_J   = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

    logic [2:0]       state, nxt_state;
    logic [1:0]       pkt;
    logic [15:0]      sr, nxt_sr;
    logic [3:0]       bit_cnt, nxt_cnt;
    logic [2:0]       ones;
    logic             stuff, lvl, pop, pop_q;
    logic [CNT_W-1:0] clk_cnt;
    logic [15:0]      crc;
    logic             bit_end, in_stream, stuff_now, accept, advance, crc_en;
    line_t            line;

    assign bit_end   = clk_cnt == CNT_W'(BIT_CLKS - 1);
    assign in_stream = state inside {ST_SYNC, ST_PID, ST_DATA, ST_CRC};
    assign stuff_now = in_stream && !stuff && ones == 3'd6;
    assign accept    = state == ST_IDLE && tx_packet != PKT_IDLE;
    assign advance   = bit_end && !stuff_now && state != ST_IDLE && state != ST_DONE;
    // CRC is fed as each data bit is launched, so it is final when the CRC field loads.
    assign crc_en    = advance && nxt_state == ST_DATA;

    // Next field position after the last real (non-stuffed) bit ends.
    always_comb begin
        nxt_state = state;
        nxt_sr    = {1'b0, sr[15:1]};
        nxt_cnt   = bit_cnt + 4'd1;
        pop       = 1'b0;
        case (state)
            ST_SYNC: if (bit_cnt == 4'd7) begin
                nxt_state = ST_PID;
                nxt_sr    = {8'h00, pid_byte(pkt)};
                nxt_cnt   = 4'd0;
            end
            ST_PID, ST_DATA: if (bit_cnt == 4'd7) begin
                nxt_cnt = 4'd0;
                if (state == ST_PID && pkt != PKT_DATA0) begin
                    nxt_state = ST_EOP_SE0;
                end else if (buffer_occupancy != 7'd0) begin
                    nxt_state = ST_DATA;
                    nxt_sr    = {8'h00, tx_packet_data};
                    pop       = 1'b1;
                end else begin
                    nxt_state = ST_CRC;
                    nxt_sr    = rev16(~crc);
                end
            end
            ST_CRC: if (bit_cnt == 4'd15) begin
                nxt_state = ST_EOP_SE0;
                nxt_cnt   = 4'd0;
            end
            ST_EOP_SE0: if (bit_cnt == 4'd1) begin
                nxt_state = ST_EOP_J;
                nxt_cnt   = 4'd0;
            end
            ST_EOP_J: nxt_state = ST_DONE;
            default:  nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            clk_cnt <= '0;
        end else if (accept || bit_end) begin
            clk_cnt <= '0;
        end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= ST_IDLE;
            pkt     <= PKT_IDLE;
            sr      <= 16'h0000;
            bit_cnt <= 4'd0;
            ones    <= 3'd0;
            stuff   <= 1'b0;
            lvl     <= 1'b1;
            pop_q   <= 1'b0;
        end else begin
            pop_q <= advance && pop;
            if (accept) begin
                state   <= ST_SYNC;
                pkt     <= tx_packet;
                sr      <= {8'h00, SYNC_BYTE};
                bit_cnt <= 4'd0;
                ones    <= {2'b00, SYNC_BYTE[0]};
                stuff   <= 1'b0;
                lvl     <= nrzi(lvl, SYNC_BYTE[0]);
            end else if (state == ST_DONE) begin
                state <= ST_IDLE;
            end else if (bit_end && state != ST_IDLE) begin
                if (stuff_now) begin
                    stuff <= 1'b1;
                    ones  <= 3'd0;
                    lvl   <= ~lvl;
                end else begin
                    stuff   <= 1'b0;
                    state   <= nxt_state;
                    sr      <= nxt_sr;
                    bit_cnt <= nxt_cnt;
                    if (nxt_state inside {ST_SYNC, ST_PID, ST_DATA, ST_CRC}) begin
                        ones <= nxt_sr[0] ? ones + 3'd1 : 3'd0;
                        lvl  <= nrzi(lvl, nxt_sr[0]);
                    end else begin
                        ones <= 3'd0;
                        lvl  <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        line = LINE_J;
        if (in_stream) line = lvl ? LINE_J : LINE_K;
        else if (state == ST_EOP_SE0) line = LINE_SE0;
    end

    assign dplus_out          = line.dp;
    assign dminus_out         = line.dm;
    assign tx_done            = state == ST_DONE;
    assign tx_busy            = state != ST_IDLE && state != ST_DONE;
    assign get_tx_packet_data = pop_q;

    usb_crc16 u_crc (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (accept),
        .en    (crc_en),
        .din   (nxt_sr[0]),
        .crc   (crc)
    );

endmodule

// File: tb/tb_usb_tx.sv
// Scoreboard bench for usb_tx: expected line symbols per packet are queued at request time
// and compared by a monitor on each tx_done; DATA0 packets are also decoded for the CRC residual.
module tb_usb_tx;
    localparam int BIT = 8;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [1:0] tx_packet;
    logic [7:0] tx_packet_data;
    logic [6:0] buffer_occupancy;
    logic       get_tx_packet_data, tx_done, tx_busy, dplus_out, dminus_out;

    int checks = 0;
    int failures = 0;
    int done_seen = 0;
    int exp_total = 0;

    logic [7:0] buf_mem [0:63];
    int         wr_ptr = 0;
    int         rd_ptr = 0;

    logic [1:0] exp_sym[$];
    int         exp_len[$];
    int         exp_lat[$];
    int         exp_pops[$];
    int         exp_bits[$];
    bit         exp_d0[$];
    logic [1:0] cap[$];
    int         pops = 0;

    always #5 clk = ~clk;

    usb_tx #(.BIT_CLKS(BIT)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .tx_packet          (tx_packet),
        .tx_packet_data     (tx_packet_data),
        .buffer_occupancy   (buffer_occupancy),
        .get_tx_packet_data (get_tx_packet_data),
        .tx_done            (tx_done),
        .tx_busy            (tx_busy),
        .dplus_out          (dplus_out),
        .dminus_out         (dminus_out)
    );

    assign tx_packet_data   = buf_mem[rd_ptr[5:0]];
    assign buffer_occupancy = 7'(wr_ptr - rd_ptr);

    always @(negedge clk) begin
        if (get_tx_packet_data) rd_ptr = rd_ptr + 1;
    end

    task automatic chk(input string nm, input longint act, input longint want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, want);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = b ^ c[15];
        return {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    endfunction

    // Reference encoder: raw bit list, bit stuffing, NRZI, then SE0 SE0 J.
    task automatic push_expect(input logic [1:0] pkt, input int n, input logic [31:0] d,
                               input int lat_hand, input int epops);
        logic       b_q[$];
        logic [7:0] sync_b, pid_b, byt;
        logic [15:0] c;
        logic       lvl;
        int         ones, len;
        sync_b = 8'h80;
        pid_b  = (pkt == 2'b01) ? 8'hC3 : (pkt == 2'b10) ? 8'hD2 : 8'h5A;
        for (int i = 0; i < 8; i++) b_q.push_back(sync_b[i]);
        for (int i = 0; i < 8; i++) b_q.push_back(pid_b[i]);
        if (pkt == 2'b01) begin
            c = 16'hFFFF;
            for (int k = 0; k < n; k++) begin
                byt = d[8*k +: 8];
                for (int i = 0; i < 8; i++) begin
                    b_q.push_back(byt[i]);
                    c = crc_step(c, byt[i]);
                end
            end
            for (int i = 15; i >= 0; i--) b_q.push_back(~c[i]);
        end
        lvl = 1'b1;
        ones = 0;
        len = 0;
        foreach (b_q[i]) begin
            if (!b_q[i]) lvl = ~lvl;
            exp_sym.push_back({lvl, ~lvl});
            len++;
            ones = b_q[i] ? ones + 1 : 0;
            if (ones == 6) begin
                lvl = ~lvl;
                exp_sym.push_back({lvl, ~lvl});
                len++;
                ones = 0;
            end
        end
        exp_sym.push_back(2'b00);
        exp_sym.push_back(2'b00);
        exp_sym.push_back(2'b10);
        len += 3;
        exp_len.push_back(len);
        exp_lat.push_back(lat_hand > 0 ? lat_hand : len * BIT);
        exp_pops.push_back(epops);
        exp_bits.push_back(b_q.size() - 16);
        exp_d0.push_back(pkt == 2'b01);
        exp_total++;
    endtask

    task automatic score_packet();
        int         len, lat, epops, ebits, mism, ones, nb;
        bit         d0;
        logic [1:0] sym, prev;
        logic [15:0] c;
        logic       b;
        len   = exp_len.pop_front();
        lat   = exp_lat.pop_front();
        epops = exp_pops.pop_front();
        ebits = exp_bits.pop_front();
        d0    = exp_d0.pop_front();
        chk("busy_in_done", tx_busy, 0);
        chk("line_j_in_done", {dplus_out, dminus_out}, 2'b10);
        chk("accept_to_done_clocks", cap.size(), lat);
        chk("pop_count", pops, epops);
        mism = 0;
        for (int i = 0; i < len * BIT; i++) begin
            sym = exp_sym[i / BIT];
            if (i >= cap.size() || cap[i] !== sym) mism++;
        end
        chk("line_symbol_mismatches", mism, 0);
        for (int i = 0; i < len; i++) sym = exp_sym.pop_front();
        if (d0) begin
            prev = 2'b10;
            ones = 0;
            nb = 0;
            c = 16'hFFFF;
            for (int k = 0; k * BIT + BIT / 2 < cap.size(); k++) begin
                sym = cap[k * BIT + BIT / 2];
                if (sym == 2'b00) break;
                b = (sym == prev);
                prev = sym;
                if (ones == 6) begin
                    ones = 0;
                    continue;
                end
                ones = b ? ones + 1 : 0;
                if (nb >= 16) c = crc_step(c, b);
                nb++;
            end
            chk("decoded_payload_bits", nb - 16, ebits);
            chk("crc_residual", c, 16'h800D);
        end
    endtask

    always @(negedge clk) begin
        if (!n_rst) begin
            cap.delete();
            pops = 0;
        end else begin
            if (tx_busy) begin
                cap.push_back({dplus_out, dminus_out});
                if (get_tx_packet_data) pops++;
            end
            if (tx_done) begin
                done_seen++;
                if (exp_len.size() == 0) chk("unexpected_tx_done", 1, 0);
                else score_packet();
                cap.delete();
                pops = 0;
            end
        end
    end

    task automatic wait_done(input int nak_at);
        int start, cyc;
        start = done_seen;
        cyc = 0;
        while (done_seen == start && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (nak_at != 0 && cyc == nak_at) tx_packet = 2'b11;
            else if (nak_at != 0 && cyc == nak_at + 1) tx_packet = 2'b00;
        end
        chk("tx_done_seen_in_budget", done_seen != start, 1);
    endtask

    task automatic load_bytes(input int n, input logic [31:0] d);
        for (int k = 0; k < n; k++) begin
            buf_mem[wr_ptr[5:0]] = d[8*k +: 8];
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic send(input logic [1:0] pkt, input int n, input logic [31:0] d,
                        input int lat, input int epops, input int nak_at);
        load_bytes(n, d);
        push_expect(pkt, n, d, lat, epops);
        tx_packet = pkt;
        @(negedge clk);
        tx_packet = 2'b00;
        wait_done(nak_at);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        n_rst = 1'b0;
        tx_packet = 2'b00;
        repeat (3) @(negedge clk);
        chk("reset_dplus", dplus_out, 1);
        chk("reset_dminus", dminus_out, 0);
        chk("reset_busy", tx_busy, 0);
        chk("reset_done", tx_done, 0);
        chk("reset_get", get_tx_packet_data, 0);
        n_rst = 1'b1;
        @(negedge clk);

        send(2'b10, 0, 32'h0, 152, 0, 0);
        send(2'b01, 0, 32'h0, 280, 0, 0);
        send(2'b01, 2, 32'h0000_FFFF, 0, 2, 0);
        send(2'b01, 4, 32'h0302_0100, 0, 4, 0);
        send(2'b10, 0, 32'h0, 152, 0, 40);

        load_bytes(4, 32'h55AA_33CC);
        tx_packet = 2'b01;
        @(negedge clk);
        tx_packet = 2'b00;
        repeat (200) @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk("midreset_dplus", dplus_out, 1);
        chk("midreset_dminus", dminus_out, 0);
        chk("midreset_busy", tx_busy, 0);
        chk("midreset_done", tx_done, 0);
        @(negedge clk);
        wr_ptr = rd_ptr;
        n_rst = 1'b1;
        push_expect(2'b10, 0, 32'h0, 152, 0);
        tx_packet = 2'b10;
        @(negedge clk);
        tx_packet = 2'b00;
        wait_done(0);

        repeat (20) @(negedge clk);
        chk("tx_done_total", done_seen, exp_total);
        chk("scoreboard_drained", exp_len.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/usb_tx.md
USB_TX -- requirements
Module: usb_tx

Interface
REQ-001 SHALL have parameter BIT_CLKS, default 8, meaning clock cycles per USB bit period.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port n_rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port tx_packet  input  2  packet request: 00 idle, 01 DATA0, 10 ACK, 11 NAK; may be a single-cycle pulse.
REQ-005 SHALL have port tx_packet_data  input  8  head byte of the data buffer, valid whenever buffer_occupancy is nonzero.
REQ-006 SHALL have port buffer_occupancy  input  7  byte count held in the data buffer.
REQ-007 SHALL have port get_tx_packet_data  output  1  one-cycle pop strobe to the data buffer.
REQ-008 SHALL have port tx_done  output  1  one-cycle pulse when a packet has been fully sent.
REQ-009 SHALL have port tx_busy  output  1  high from packet acceptance until tx_done.
REQ-010 SHALL have ports dplus_out and dminus_out  output  1 each  USB line drive.

Function
REQ-011 SHALL, in IDLE, accept a nonzero tx_packet by latching it, asserting tx_busy next cycle and entering SYNC; 00 SHALL be ignored.
REQ-012 SHALL ignore tx_packet while tx_busy is high.
REQ-013 SHALL use the states IDLE, SYNC, PID, DATA, CRC, EOP_SE0, EOP_J and DONE.
REQ-014 SHALL sequence SYNC -> PID -> (DATA -> CRC, for DATA0 only) -> EOP_SE0 -> EOP_J -> DONE -> IDLE.
REQ-015 SHALL send SYNC as byte 0x80 and PID bytes as 0xC3 (DATA0), 0xD2 (ACK) and 0x5A (NAK); every field SHALL be sent LSB first.
REQ-016 SHALL, at each DATA byte boundary (including the first), pop tx_packet_data into the shift register with a one-cycle get_tx_packet_data if buffer_occupancy != 0, otherwise go to CRC.
REQ-017 SHALL, for a DATA0 packet with buffer_occupancy == 0 at PID end, send zero data bytes followed by CRC 0x0000.
REQ-018 SHALL compute CRC16 (polynomial x^16+x^15+x^2+1, init 0xFFFF) over DATA bits only, and transmit its ones-complement LSB first.
REQ-019 SHALL NRZI-encode the bitstream: a 0 toggles the line and a 1 holds it; J is dplus=1, dminus=0 and K is the inverse.
REQ-020 SHALL insert a stuffed 0 after six consecutive 1s from SYNC through CRC; the ones-run counter SHALL include SYNC's final 1.
REQ-021 SHALL, during a stuffed bit, hold the shift register and CRC and not count the stuffed bit toward field length.
REQ-022 SHALL insert a stuffed bit owed after the final CRC bit before EOP_SE0 begins.
REQ-023 SHALL hold each bit for exactly BIT_CLKS cycles using a free-running bit-period counter that is restarted on packet acceptance.
REQ-024 SHALL drive EOP as SE0 (dplus=0, dminus=0) for 2 bit periods, then J for 1 bit period.
REQ-025 SHALL pulse tx_done in DONE for one cycle and deassert tx_busy in the same cycle.
REQ-026 SHALL drive J on the lines whenever in IDLE or DONE.

Reset
REQ-027 SHALL, while n_rst is low, immediately drive state IDLE, dplus_out=1, dminus_out=0, tx_done=0, tx_busy=0, get_tx_packet_data=0, and clear all counters, CRC and the shift register.
REQ-028 SHALL, on reset mid-packet, abandon the packet without a tx_done pulse and accept a new request on the first cycle after release.

Structure
REQ-029 SHALL import a shared package usb_pkg holding the tx_packet codes, PID byte constants, SYNC byte, CRC polynomial/init and J/K/SE0 encodings; the controller SHALL use the same package.
REQ-030 SHALL instantiate one sub-module usb_crc16 (serial CRC16 with clear, enable and data-bit inputs) and keep the stuffing/NRZI logic inline.

Verification
REQ-031 SHALL verify ACK: one-cycle tx_packet=10 -> NRZI of 0x80 then 0xD2, no stuffing, SE0 16 clocks, J 8 clocks, tx_done pulse exactly 152 clocks after acceptance.
REQ-032 SHALL verify zero-length DATA0: tx_packet=01 with occupancy 0 -> 0x80, 0xC3, 16 zero bits, EOP, tx_done at 280 clocks, get_tx_packet_data never asserted.
REQ-033 SHALL verify DATA0 with bytes 0xFF,0xFF: stuffed 0 after every six 1s with 2 pops in total, and a bench decode (de-NRZI, de-stuff, CRC over data+CRC) yields residual 0x800D.
REQ-034 SHALL verify DATA0 with bytes 0x00,0x01,0x02,0x03: exactly 4 get_tx_packet_data pulses, one per byte boundary, and the CRC field matches the bench reference model.
REQ-035 SHALL verify tx_packet=11 pulsed mid-packet -> ignored, with the current packet completing unchanged and exactly one tx_done.
REQ-036 SHALL verify n_rst asserted mid-DATA -> lines at J immediately, no tx_done, and a following ACK request transmitted correctly.
